// File: rtl/dircc_system_states_pkg.sv
// rtl/dircc_system_states_pkg.sv - shared thread/packet types and receive dispatcher FSM states
package dircc_system_states_pkg;

    localparam int THREAD_COUNT        = 8;
    localparam int DIRCC_STATE_STOPPED = 2;

    typedef struct packed {
        logic [7:0]  kind;
        logic [23:0] payload;
    } packet_data_t;

    typedef struct packed {
        logic [7:0]  dircc_state;
        logic [31:0] accumulate;
    } device_state_t;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        DISPATCH,
        WAIT,
        WRITEBACK
    } receive_dispatch_state_t;

endpackage

// File: rtl/dircc_receive_timeout.sv
// rtl/dircc_receive_timeout.sv - loadable down-counter flagging an expired handler wait
module dircc_receive_timeout #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             count_en,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/dircc_receive_dispatcher.sv
// rtl/dircc_receive_dispatcher.sv - serialising read/dispatch/writeback sequencer for the receive handler
// Optional: DIRCC_RECEIVE_DROP_STOPPED_EN drops packets addressed to stopped devices.
module dircc_receive_dispatcher
    import dircc_system_states_pkg::*;
#(
    parameter int ADDRESS_MEM_WIDTH = 32,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  packet_data_t                 packet_in,
    input  logic [ADDRESS_MEM_WIDTH-1:0] packet_dest,
    input  logic [7:0]                   edge_id_in,
    input  logic [7:0]                   port_id_in,
    input  logic                         packet_in_valid,
    output logic                         packet_in_ready,
    output logic                         state_rd_en,
    output logic [ADDRESS_MEM_WIDTH-1:0] state_rd_address,
    input  device_state_t                state_rd_data,
    output logic [ADDRESS_MEM_WIDTH-1:0] address,
    output logic                         receive_done,
    output packet_data_t                 packet_out,
    output logic                         packet_out_valid,
    output logic [7:0]                   edge_id,
    output logic [7:0]                   port_id,
    output device_state_t                read_state,
    input  logic                         packet_handled,
    input  device_state_t                write_state,
    input  logic                         write_state_valid,
    output logic                         state_wr_en,
    output logic [ADDRESS_MEM_WIDTH-1:0] state_wr_address,
    output device_state_t                state_wr_data,
    output logic                         busy,
    output logic                         error_timeout,
    output logic [15:0]                  drop_count
);

    // Counter is loaded with N-1 so the response is still accepted in the Nth WAIT cycle.
    localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT_CYCLES - 1);

    receive_dispatch_state_t state_q, state_d;

    logic [ADDRESS_MEM_WIDTH-1:0] dest_q, dest_d;
    packet_data_t                 pkt_q, pkt_d;
    logic [7:0]                   edge_q, edge_d;
    logic [7:0]                   port_q, port_d;
    device_state_t                read_state_q, read_state_d;
    device_state_t                wr_data_q, wr_data_d;
    logic                         error_q, error_d;
    logic [15:0]                  drop_q, drop_d;
    logic                         drop_inc;
    logic                         timer_load;
    logic                         timer_expired;

    dircc_receive_timeout #(
        .WIDTH(16)
    ) u_timeout (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (TIMEOUT_LOAD),
        .count_en   (state_q == WAIT),
        .expired    (timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        dest_d       = dest_q;
        pkt_d        = pkt_q;
        edge_d       = edge_q;
        port_d       = port_q;
        read_state_d = read_state_q;
        wr_data_d    = wr_data_q;
        error_d      = error_q;
        drop_inc     = 1'b0;
        timer_load   = 1'b0;

        case (state_q)
            IDLE: begin
                if (packet_in_valid) begin
                    dest_d = packet_dest;
                    pkt_d  = packet_in;
                    edge_d = edge_id_in;
                    port_d = port_id_in;
                    if (packet_dest >= ADDRESS_MEM_WIDTH'(THREAD_COUNT)) begin
                        drop_inc = 1'b1;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                read_state_d = state_rd_data;
`ifdef DIRCC_RECEIVE_DROP_STOPPED_EN
                if (state_rd_data.dircc_state[DIRCC_STATE_STOPPED]) begin
                    drop_inc = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d = DISPATCH;
                end
`else
                state_d = DISPATCH;
`endif
            end
            DISPATCH: begin
                timer_load = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                if (write_state_valid || packet_handled) begin
                    wr_data_d = write_state;
                    state_d   = WRITEBACK;
                end else if (timer_expired) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end
            WRITEBACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        drop_d = (drop_inc && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            dest_q       <= '0;
            pkt_q        <= '0;
            edge_q       <= '0;
            port_q       <= '0;
            read_state_q <= '0;
            wr_data_q    <= '0;
            error_q      <= 1'b0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            dest_q       <= dest_d;
            pkt_q        <= pkt_d;
            edge_q       <= edge_d;
            port_q       <= port_d;
            read_state_q <= read_state_d;
            wr_data_q    <= wr_data_d;
            error_q      <= error_d;
            drop_q       <= drop_d;
        end
    end

    assign packet_in_ready  = (state_q == IDLE);
    assign busy             = (state_q != IDLE);
    assign state_rd_en      = (state_q == READ);
    assign state_rd_address = dest_q;
    assign receive_done     = (state_q == DISPATCH);
    assign packet_out_valid = (state_q == DISPATCH);
    assign state_wr_en      = (state_q == WRITEBACK);
    assign state_wr_address = dest_q;
    assign state_wr_data    = wr_data_q;
    assign address          = dest_q;
    assign packet_out       = pkt_q;
    assign edge_id          = edge_q;
    assign port_id          = port_q;
    assign read_state       = read_state_q;
    assign error_timeout    = error_q;
    assign drop_count       = drop_q;

endmodule

// File: doc/dircc_receive_dispatcher.md
# dircc_receive_dispatcher

Upstream sequencer for `dircc_receive_handler`. It accepts one inbound packet at a time from the network interface and fetches the destination device's state from the thread state memory. It then presents packet and state to the handler with a one-cycle `receive_done` strobe, waits for the handler's updated state, and writes that state back to memory. It serialises receives per tile, so read-modify-write hazards on device state cannot occur.

## Interface
- `ADDRESS_MEM_WIDTH`, 32: width of thread/state-memory addresses.
- `TIMEOUT_CYCLES`, 255: maximum cycles to wait for the handler after `receive_done`; range 1..65535.
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `packet_in` in `packet_data_t`: inbound packet payload.
- `packet_dest` in `ADDRESS_MEM_WIDTH`: destination thread address.
- `edge_id_in`, `port_id_in` in 8 each: edge and port of the inbound packet.
- `packet_in_valid` in 1: inbound packet valid.
- `packet_in_ready` out 1: dispatcher can accept.
- `state_rd_en` out 1: state memory read strobe.
- `state_rd_address` out `ADDRESS_MEM_WIDTH`: state memory read address.
- `state_rd_data` in `device_state_t`: read data, valid exactly 1 cycle after `state_rd_en`.
- `address` out `ADDRESS_MEM_WIDTH`: thread address to the handler.
- `receive_done` out 1: one-cycle dispatch strobe.
- `packet_out` out `packet_data_t`: packet to the handler.
- `packet_out_valid` out 1: packet to the handler is valid.
- `edge_id`, `port_id` out 8 each: edge and port to the handler.
- `read_state` out `device_state_t`: captured device state.
- `packet_handled` in 1: handler completion.
- `write_state` in `device_state_t`: updated state from the handler.
- `write_state_valid` in 1: `write_state` valid.
- `state_wr_en` out 1: state memory write strobe.
- `state_wr_address` out `ADDRESS_MEM_WIDTH`: state memory write address.
- `state_wr_data` out `device_state_t`: state memory write data.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `error_timeout` out 1: sticky; set when the handler fails to respond.
- `drop_count` out 16: number of dropped packets; saturates at 0xFFFF.

## Operation
- FSM states and transitions:
  - IDLE: `packet_in_ready`=1. On `packet_in_valid`, capture `packet_in`, `packet_dest`, `edge_id_in` and `port_id_in`.
    - If `packet_dest` >= `THREAD_COUNT`: drop the packet (`drop_count`+1) and stay in IDLE.
    - Otherwise go to READ.
  - READ: `state_rd_en`=1, `state_rd_address`=captured destination. Go to CAPTURE.
  - CAPTURE: register `state_rd_data` into `read_state`. Go to DISPATCH.
  - DISPATCH: `receive_done`=1 and `packet_out_valid`=1 for exactly this cycle. Load the timeout counter. Go to WAIT.
  - WAIT: on `write_state_valid`, register `write_state` into `state_wr_data` and go to WRITEBACK. `packet_handled` is accepted as completion equivalently. If the counter expires first, set `error_timeout` and go to IDLE with no write.
  - WRITEBACK: `state_wr_en`=1, `state_wr_address`=captured destination. Go to IDLE.
- While not in IDLE, `address`, `packet_out`, `edge_id`, `port_id` and `read_state` are held stable. The handler derives `dircc_state_extra` combinationally from `read_state`.
- A `write_state_valid` arriving outside WAIT is ignored.
- `drop_count` saturates rather than wrapping.
- Reset values: all outputs 0 except `packet_in_ready`, which is 1 (IDLE). A reset mid-operation abandons the packet and issues no memory write.

## Timing
- Cycle 0: accept in IDLE.
- Cycle 1: READ.
- Cycle 2: CAPTURE.
- Cycle 3: `receive_done`.
- Cycle 4: the handler's registered `write_state_valid` is normally seen.
- Cycle 5: `state_wr_en`.
- Cycle 6: `packet_in_ready` high again. Minimum throughput is one packet per 6 cycles.
- Timeout fires if no response has been seen by the cycle `TIMEOUT_CYCLES` after DISPATCH.
- An out-of-range drop costs one cycle; `packet_in_ready` stays high.

## Configuration
- `DIRCC_RECEIVE_DROP_STOPPED_EN`
  - Defined: in CAPTURE, if the `DIRCC_STATE_STOPPED` bit of `state_rd_data.dircc_state` is set, skip dispatch. Increment `drop_count` and return to IDLE; there is no `receive_done` and no write.
  - Undefined: every in-range packet is dispatched regardless of device state.

## Structure
- Add the `receive_dispatch_state_t` enum (IDLE, READ, CAPTURE, DISPATCH, WAIT, WRITEBACK) to `dircc_system_states_pkg`.
- Reuse `packet_data_t`, `device_state_t` and `THREAD_COUNT` from the existing packages.
- Sub-module `dircc_receive_timeout`: a loadable down-counter with `expired` output.

## Test plan
- Packet for dest 2, state accumulate=5: `receive_done` in cycle 3; handler returns accumulate=12; `state_wr_en` in cycle 5 with addr 2, data accumulate=12.
- `packet_dest` = `THREAD_COUNT`: no `state_rd_en`, `drop_count` 0→1, `packet_in_ready` stays 1.
- Handler silent, `TIMEOUT_CYCLES`=4: `error_timeout`=1 after 4 WAIT cycles, no `state_wr_en`, next packet accepted.
- With `DIRCC_RECEIVE_DROP_STOPPED_EN` and dest state `DIRCC_STATE_STOPPED`: no `receive_done`, `drop_count` increments. Without the macro the same stimulus dispatches normally.
- Two back-to-back valid packets: second accepted only in cycle 6; the writes land in order with no overlap.
- `reset_n` low during WAIT: all outputs 0 and IDLE; a late `write_state_valid` after reset produces no write.
